// File: rtl/pipelined_if_stage_pkg.sv
// Shared encodings for the instruction-fetch stage: next-PC select codes,
// fetch FSM states and the default NOP word.
package pipelined_if_stage_pkg;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_JR  = 2'b10;
   localparam logic [1:0] PCSRC_J   = 2'b11;

   localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      HAVE = 2'b10
   } if_state_e;

   function automatic logic [31:0] pc_incr(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/pipelined_if_stage_if.sv
// Request/ready handshake between the fetch stage (master) and a
// variable-latency instruction memory (slave).
interface pipelined_if_stage_if;

   logic        req;
   logic [31:0] addr;
   logic        ready;
   logic [31:0] rdata;

   modport master (
      output req,
      output addr,
      input  ready,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output ready,
      output rdata
   );

endinterface

// File: rtl/pipelined_if_stage_pc_next_mux.sv
// Combinational 4:1 next-PC selector: pc+4, branch, register-jump or jump target.
module pc_next_mux
   import pipelined_if_stage_pkg::*;
(
   input  logic [1:0]  i_pcsource,
   input  logic [31:0] i_pc_plus4,
   input  logic [31:0] i_bpc,
   input  logic [31:0] i_rpc,
   input  logic [31:0] i_jpc,
   output logic [31:0] o_next_pc
);

   always_comb begin
      o_next_pc = i_pc_plus4;
      unique case (i_pcsource)
         PCSRC_SEQ: o_next_pc = i_pc_plus4;
         PCSRC_BR:  o_next_pc = i_bpc;
         PCSRC_JR:  o_next_pc = i_rpc;
         PCSRC_J:   o_next_pc = i_jpc;
         default:   o_next_pc = i_pc_plus4;
      endcase
   end

endmodule

// File: rtl/pipelined_if_stage.sv
// Instruction-fetch stage feeding the IF/ID register: PC, imem handshake,
// stall buffer and redirect squash. IF_STALL_CNT_EN adds a saturating stall counter.
module pipelined_if_stage
   import pipelined_if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
`ifdef IF_STALL_CNT_EN
   ,
   parameter int unsigned PERF_W   = 32
`endif
) (
   input  logic                  Clk,
   input  logic                  Clrn,
   input  logic                  wpcir,
   input  logic [1:0]            pcsource,
   input  logic [31:0]           bpc,
   input  logic [31:0]           rpc,
   input  logic [31:0]           jpc,
   pipelined_if_stage_if.master  imem,
   output logic [31:0]           PC_plus4,
   output logic [31:0]           IF_Inst,
   output logic                  if_valid,
   output logic                  if_stall
`ifdef IF_STALL_CNT_EN
   ,
   output logic [PERF_W-1:0]     stall_cnt
`endif
);

   if_state_e   r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic        r_kill, w_kill_nxt;
   logic [31:0] r_redir_pc, w_redir_pc_nxt;
   logic [31:0] r_inst_buf, w_inst_buf_nxt;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_mux_pc;
   logic        w_fetch_ok;
   logic        w_redirect;
   logic        w_advance;

   assign w_pc_plus4 = pc_incr(r_pc);

   pc_next_mux u_pc_next_mux (
      .i_pcsource (pcsource),
      .i_pc_plus4 (w_pc_plus4),
      .i_bpc      (bpc),
      .i_rpc      (rpc),
      .i_jpc      (jpc),
      .o_next_pc  (w_mux_pc)
   );

   always_comb begin
      w_fetch_ok = (r_state == BUSY) && imem.ready && !r_kill;
      if_valid   = w_fetch_ok || (r_state == HAVE);
      if_stall   = ~if_valid;
      imem.req   = (r_state == BUSY);
      imem.addr  = r_pc;
      PC_plus4   = w_pc_plus4;
      if (r_state == HAVE)  IF_Inst = r_inst_buf;
      else if (w_fetch_ok)  IF_Inst = imem.rdata;
      else                  IF_Inst = NOP_INST;
      w_redirect = wpcir && (pcsource != PCSRC_SEQ);
      w_advance  = wpcir && (pcsource == PCSRC_SEQ) && if_valid;
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_kill_nxt     = r_kill;
      w_redir_pc_nxt = r_redir_pc;
      w_inst_buf_nxt = r_inst_buf;
      unique case (r_state)
         IDLE: w_state_nxt = BUSY;
         BUSY: begin
            if (!imem.ready) begin
               // Request must stay stable; remember the redirect for later
               if (w_redirect) begin
                  w_kill_nxt     = 1'b1;
                  w_redir_pc_nxt = w_mux_pc;
               end
            end else if (r_kill) begin
               w_pc_nxt   = w_redirect ? w_mux_pc : r_redir_pc;
               w_kill_nxt = 1'b0;
            end else if (w_redirect || w_advance) begin
               w_pc_nxt = w_mux_pc;
            end else begin
               w_inst_buf_nxt = imem.rdata;
               w_state_nxt    = HAVE;
            end
         end
         HAVE: begin
            if (w_redirect || w_advance) begin
               w_pc_nxt    = w_mux_pc;
               w_state_nxt = BUSY;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Clrn) begin
         r_state    <= IDLE;
         r_pc       <= RESET_PC;
         r_kill     <= 1'b0;
         r_redir_pc <= RESET_PC;
         r_inst_buf <= NOP_INST;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_kill     <= w_kill_nxt;
         r_redir_pc <= w_redir_pc_nxt;
         r_inst_buf <= w_inst_buf_nxt;
      end
   end

`ifdef IF_STALL_CNT_EN
   logic [PERF_W-1:0] r_stall_cnt;

   always_ff @(posedge Clk) begin
      if (!Clrn) begin
         r_stall_cnt <= '0;
      end else if ((r_state == BUSY) && !if_valid && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipelined_if_stage.sv
// Bench for pipelined_if_stage: table-driven cycles plus hand-written redirect,
// reset and wrap sequences against a latency-programmable memory model.
module tb_pipelined_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        Clrn;
   logic        wpcir;
   logic [1:0]  pcsource;
   logic [31:0] bpc, rpc, jpc;
   logic [31:0] PC_plus4, IF_Inst;
   logic        if_valid, if_stall;
`ifdef IF_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int          total = 0;
   int          bad   = 0;
   int          lat   = 1;
   int          wait_cnt = 0;
   logic        force_rdy = 1'b0;
   logic [63:0] sb_q[$];

   pipelined_if_stage_if u_imem ();

   pipelined_if_stage dut (
      .Clk       (clk),
      .Clrn      (Clrn),
      .wpcir     (wpcir),
      .pcsource  (pcsource),
      .bpc       (bpc),
      .rpc       (rpc),
      .jpc       (jpc),
      .imem      (u_imem.master),
      .PC_plus4  (PC_plus4),
      .IF_Inst   (IF_Inst),
      .if_valid  (if_valid),
      .if_stall  (if_stall)
`ifdef IF_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   // Memory model: ready once the request has been held lat-1 cycles
   assign u_imem.ready = (u_imem.req && (wait_cnt >= lat - 1)) || force_rdy;
   assign u_imem.rdata = inst_of(u_imem.addr);

   always @(posedge clk) begin
      if (u_imem.req === 1'b1 && u_imem.ready === 1'b0) wait_cnt <= wait_cnt + 1;
      else                                               wait_cnt <= 0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive at posedge+1, sample at negedge
   task automatic step(input int l, input logic w, input logic [1:0] ps, input logic er,
                       input logic [31:0] ea, input logic ev, input logic [31:0] ei,
                       input logic [31:0] ep4);
      logic [63:0] e;
      lat = l; wpcir = w; pcsource = ps;
      if (w && ps == 2'b00 && ev) sb_q.push_back({ep4, ei});
      @(negedge clk);
      chk("imem_req", {31'd0, u_imem.req}, {31'd0, er});
      if (er) chk("imem_addr", u_imem.addr, ea);
      chk("if_valid", {31'd0, if_valid}, {31'd0, ev});
      chk("if_stall", {31'd0, if_stall}, {31'd0, ~ev});
      chk("IF_Inst", IF_Inst, ei);
      chk("PC_plus4", PC_plus4, ep4);
      if (if_valid === 1'b1 && wpcir && pcsource == 2'b00) begin
         if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_underflow: got accepted %h want none", IF_Inst);
         end else begin
            e = sb_q.pop_front();
            chk("sb_inst", IF_Inst, e[31:0]);
            chk("sb_pc4", PC_plus4, e[63:32]);
         end
      end
      @(posedge clk); #1;
   endtask

   typedef struct {
      int          l;
      logic        w;
      logic [1:0]  ps;
      logic        er;
      logic [31:0] ea;
      logic        ev;
      logic [31:0] ei;
      logic [31:0] ep4;
   } vec_t;

   vec_t tbl[$];

   initial begin
      // Zero-wait stream, 4-cycle stall into HAVE, then a latency-3 fetch
      tbl.push_back('{1, 1'b1, 2'b00, 1'b0, 32'h00, 1'b0, NOP,           32'h04});
      tbl.push_back('{1, 1'b1, 2'b00, 1'b1, 32'h00, 1'b1, inst_of(32'h00), 32'h04});
      tbl.push_back('{1, 1'b1, 2'b00, 1'b1, 32'h04, 1'b1, inst_of(32'h04), 32'h08});
      tbl.push_back('{1, 1'b1, 2'b00, 1'b1, 32'h08, 1'b1, inst_of(32'h08), 32'h0C});
      tbl.push_back('{1, 1'b1, 2'b00, 1'b1, 32'h0C, 1'b1, inst_of(32'h0C), 32'h10});
      tbl.push_back('{1, 1'b0, 2'b00, 1'b1, 32'h10, 1'b1, inst_of(32'h10), 32'h14});
      for (int i = 0; i < 3; i++)
         tbl.push_back('{1, 1'b0, 2'b00, 1'b0, 32'h10, 1'b1, inst_of(32'h10), 32'h14});
      tbl.push_back('{1, 1'b1, 2'b00, 1'b0, 32'h10, 1'b1, inst_of(32'h10), 32'h14});
      tbl.push_back('{1, 1'b1, 2'b00, 1'b1, 32'h14, 1'b1, inst_of(32'h14), 32'h18});
      tbl.push_back('{3, 1'b1, 2'b00, 1'b1, 32'h18, 1'b0, NOP,           32'h1C});
      tbl.push_back('{3, 1'b1, 2'b00, 1'b1, 32'h18, 1'b0, NOP,           32'h1C});
      tbl.push_back('{3, 1'b1, 2'b00, 1'b1, 32'h18, 1'b1, inst_of(32'h18), 32'h1C});

      Clrn = 1'b0; wpcir = 1'b0; pcsource = 2'b00;
      bpc = '0; rpc = '0; jpc = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", {31'd0, u_imem.req}, 32'd0);
      chk("rst_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_inst", IF_Inst, NOP);
      chk("rst_pc4", PC_plus4, 32'h4);
      Clrn = 1'b1;

      foreach (tbl[i])
         step(tbl[i].l, tbl[i].w, tbl[i].ps, tbl[i].er, tbl[i].ea, tbl[i].ev, tbl[i].ei,
              tbl[i].ep4);
`ifdef IF_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, 32'd2);
`endif

      // Branch while fetch outstanding: word from 0x1C dropped, resume at 0x100
      bpc = 32'h100;
      step(3, 1'b1, 2'b01, 1'b1, 32'h1C, 1'b0, NOP, 32'h20);
      step(3, 1'b1, 2'b00, 1'b1, 32'h1C, 1'b0, NOP, 32'h20);
      step(3, 1'b0, 2'b00, 1'b1, 32'h1C, 1'b0, NOP, 32'h20);
      step(1, 1'b1, 2'b00, 1'b1, 32'h100, 1'b1, inst_of(32'h100), 32'h104);

      // Two redirects while kill pending: last one (0x300) wins
      jpc = 32'h200; rpc = 32'h300;
      step(3, 1'b1, 2'b11, 1'b1, 32'h104, 1'b0, NOP, 32'h108);
      step(3, 1'b1, 2'b10, 1'b1, 32'h104, 1'b0, NOP, 32'h108);
      step(3, 1'b0, 2'b00, 1'b1, 32'h104, 1'b0, NOP, 32'h108);
      step(1, 1'b1, 2'b00, 1'b1, 32'h300, 1'b1, inst_of(32'h300), 32'h304);

      // Reset mid-fetch, then a stray ready while idle
      step(3, 1'b0, 2'b00, 1'b1, 32'h304, 1'b0, NOP, 32'h308);
      Clrn = 1'b0;
      step(3, 1'b0, 2'b00, 1'b1, 32'h304, 1'b0, NOP, 32'h308);
      Clrn = 1'b1; force_rdy = 1'b1;
      step(3, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, NOP, 32'h4);
      force_rdy = 1'b0;
      step(3, 1'b0, 2'b00, 1'b1, 32'h0, 1'b0, NOP, 32'h4);
      step(1, 1'b1, 2'b00, 1'b1, 32'h0, 1'b1, inst_of(32'h0), 32'h4);

      // Jump to top of address space and wrap to zero
      jpc = 32'hFFFF_FFFC;
      step(1, 1'b1, 2'b11, 1'b1, 32'h4, 1'b1, inst_of(32'h4), 32'h8);
      step(1, 1'b1, 2'b00, 1'b1, 32'hFFFF_FFFC, 1'b1, inst_of(32'hFFFF_FFFC), 32'h0);
      step(1, 1'b1, 2'b00, 1'b1, 32'h0, 1'b1, inst_of(32'h0), 32'h4);

      // Redirect out of HAVE
      bpc = 32'h40;
      step(1, 1'b0, 2'b00, 1'b1, 32'h4, 1'b1, inst_of(32'h4), 32'h8);
      step(1, 1'b1, 2'b01, 1'b0, 32'h4, 1'b1, inst_of(32'h4), 32'h8);
      step(1, 1'b1, 2'b00, 1'b1, 32'h40, 1'b1, inst_of(32'h40), 32'h44);

      chk("sb_empty", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
